// File: rtl/thirty_two_bit_adder_pkg.sv
// Shared types and sizing for the 32-bit adder/subtractor and its CLA blocks.
package thirty_two_bit_adder_pkg;

    localparam int BLK_W      = 4;
    localparam int NUM_BLOCKS = 8;

    typedef struct packed {
        logic [NUM_BLOCKS*BLK_W-1:0] sum;
        logic                        cout;
        logic                        ovf;
    } add_result_t;

endpackage

// File: rtl/thirty_two_bit_adder_cla4.sv
// 4-bit carry-lookahead slice; c3 (carry into the top bit) is brought out for the overflow XOR.
module thirty_two_bit_adder_cla4
    import thirty_two_bit_adder_pkg::*;
(
    input  logic [BLK_W-1:0] a,
    input  logic [BLK_W-1:0] b,
    input  logic             cin,
    output logic [BLK_W-1:0] sum,
    output logic             cout,
    output logic             c3
);

    logic [BLK_W-1:0] g;
    logic [BLK_W-1:0] p;
    logic [BLK_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Carries expanded from cin so no bit waits on its neighbour.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum  = p ^ c[BLK_W-1:0];
    assign cout = c[4];
    assign c3   = c[3];

endmodule

// File: rtl/thirty_two_bit_adder.sv
// 32-bit add/subtract core with carry-out and signed overflow; optional output register.
module thirty_two_bit_adder
    import thirty_two_bit_adder_pkg::*;
#(
    parameter bit REGISTERED = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        op,
    output logic [31:0] SUM,
    output logic        Cout,
    output logic        overflow
);

    localparam int WIDTH = 32;

    logic [WIDTH-1:0]      b_eff;
    logic [NUM_BLOCKS:0]   carry;
    logic [NUM_BLOCKS-1:0] blk_c3;
    add_result_t           res_d;

    // Subtract is A + ~B + 1: invert B and feed op in as the carry.
    assign b_eff    = B ^ {WIDTH{op}};
    assign carry[0] = op;

    for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
        thirty_two_bit_adder_cla4 u_cla4 (
            .a    (A[i*BLK_W +: BLK_W]),
            .b    (b_eff[i*BLK_W +: BLK_W]),
            .cin  (carry[i]),
            .sum  (res_d.sum[i*BLK_W +: BLK_W]),
            .cout (carry[i+1]),
            .c3   (blk_c3[i])
        );
    end

    assign res_d.cout = carry[NUM_BLOCKS];
    assign res_d.ovf  = blk_c3[NUM_BLOCKS-1] ^ carry[NUM_BLOCKS];

    logic unused_c3;
    assign unused_c3 = ^blk_c3[NUM_BLOCKS-2:0];

    if (REGISTERED) begin : g_reg
        add_result_t res_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                res_q <= '0;
            end else begin
                res_q <= res_d;
            end
        end

        assign SUM      = res_q.sum;
        assign Cout     = res_q.cout;
        assign overflow = res_q.ovf;
    end else begin : g_comb
        // Clock and reset are deliberately dead in this mode.
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ reset;

        assign SUM      = res_d.sum;
        assign Cout     = res_d.cout;
        assign overflow = res_d.ovf;
    end

endmodule

// File: tb/tb_thirty_two_bit_adder.sv
// Self-checking bench: combinational and registered instances against an arithmetic reference model.
module tb_thirty_two_bit_adder;

    logic        clk;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic        op;

    logic [31:0] sum_c, sum_r;
    logic        cout_c, cout_r;
    logic        ovf_c, ovf_r;

    int tests;
    int fails;

    thirty_two_bit_adder #(.REGISTERED(1'b0)) dut_c (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op),
        .SUM(sum_c), .Cout(cout_c), .overflow(ovf_c)
    );

    thirty_two_bit_adder #(.REGISTERED(1'b1)) dut_r (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op),
        .SUM(sum_r), .Cout(cout_r), .overflow(ovf_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {cout, ovf, sum} from plain arithmetic and sign rules.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b, input logic o);
        logic [32:0] w;
        logic [31:0] s;
        logic        c;
        logic        v;
        if (!o) begin
            w = {1'b0, a} + {1'b0, b};
            s = w[31:0];
            c = w[32];
            v = (a[31] == b[31]) && (s[31] != a[31]);
        end else begin
            s = a - b;
            c = (a >= b);
            v = (a[31] != b[31]) && (s[31] != a[31]);
        end
        return {c, v, s};
    endfunction

    function automatic logic [31:0] pick_operand();
        logic [31:0] pool [6];
        pool[0] = 32'h0000_0000; pool[1] = 32'hFFFF_FFFF; pool[2] = 32'h8000_0000;
        pool[3] = 32'h7FFF_FFFF; pool[4] = 32'h0000_0001; pool[5] = 32'h8000_0001;
        if ($urandom_range(0, 3) == 0) return pool[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    task automatic test_reset();
        logic [33:0] exp;
        @(posedge clk); #1;
        reset = 1'b1; A = 32'h7FFF_FFFF; B = 32'h0000_0001; op = 1'b0;
        exp = model(A, B, op);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            tests++;
            if ({cout_r, ovf_r, sum_r} !== 34'h0) begin
                fails++;
                $display("FAIL reset_hold[%0d]: got sum=%h cout=%b ovf=%b, expected all zero", k, sum_r, cout_r, ovf_r);
            end
            tests++;
            if ({cout_c, ovf_c, sum_c} !== exp) begin
                fails++;
                $display("FAIL comb_during_reset: got %h, expected %h", {cout_c, ovf_c, sum_c}, exp);
            end
        end
        reset = 1'b0;
        #3;
        tests++;
        if ({cout_r, ovf_r, sum_r} !== 34'h0) begin
            fails++;
            $display("FAIL reset_release_same_cycle: got %h, expected 0", {cout_r, ovf_r, sum_r});
        end
        @(posedge clk); #1;
        tests++;
        if ({cout_r, ovf_r, sum_r} !== exp) begin
            fails++;
            $display("FAIL reset_first_result: got %h, expected %h", {cout_r, ovf_r, sum_r}, exp);
        end
    endtask

    task automatic test_directed();
        logic [31:0] ta [7];
        logic [31:0] tb [7];
        logic        to [7];
        logic [31:0] ts [7];
        logic        tc [7];
        logic        tv [7];
        logic        tl [7];
        ta[0]=32'h8000_0000; tb[0]=32'h0000_0000; to[0]=1; ts[0]=32'h8000_0000; tc[0]=1; tv[0]=0; tl[0]=1;
        ta[1]=32'h8000_0000; tb[1]=32'h3B9A_CA00; to[1]=1; ts[1]=32'h4465_3600; tc[1]=1; tv[1]=1; tl[1]=1;
        ta[2]=32'h0000_0001; tb[2]=32'h8000_0000; to[2]=1; ts[2]=32'h8000_0001; tc[2]=0; tv[2]=1; tl[2]=0;
        ta[3]=32'h0000_0032; tb[3]=32'h0000_003C; to[3]=1; ts[3]=32'hFFFF_FFF6; tc[3]=0; tv[3]=0; tl[3]=1;
        ta[4]=32'h8000_0000; tb[4]=32'h8000_0000; to[4]=1; ts[4]=32'h0000_0000; tc[4]=1; tv[4]=0; tl[4]=0;
        ta[5]=32'h7FFF_FFFF; tb[5]=32'h0000_0001; to[5]=0; ts[5]=32'h8000_0000; tc[5]=0; tv[5]=1; tl[5]=0;
        ta[6]=32'hFFFF_FFFF; tb[6]=32'h0000_0001; to[6]=0; ts[6]=32'h0000_0000; tc[6]=1; tv[6]=0; tl[6]=0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            A = ta[i]; B = tb[i]; op = to[i];
            #1;
            tests++;
            if ({cout_c, ovf_c, sum_c} !== {tc[i], tv[i], ts[i]}) begin
                fails++;
                $display("FAIL directed_comb[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         i, sum_c, cout_c, ovf_c, ts[i], tc[i], tv[i]);
            end
            if (to[i]) begin
                tests++;
                if ((sum_c[31] ^ ovf_c) !== tl[i]) begin
                    fails++;
                    $display("FAIL directed_slt[%0d]: got %b, expected %b", i, sum_c[31] ^ ovf_c, tl[i]);
                end
            end
            @(posedge clk); #1;
            tests++;
            if ({cout_r, ovf_r, sum_r} !== {tc[i], tv[i], ts[i]}) begin
                fails++;
                $display("FAIL directed_reg[%0d]: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                         i, sum_r, cout_r, ovf_r, ts[i], tc[i], tv[i]);
            end
        end
    endtask

    task automatic test_random_comb();
        logic [33:0] exp;
        for (int i = 0; i < 300; i++) begin
            A = pick_operand(); B = pick_operand(); op = 1'($urandom_range(0, 1));
            #1;
            exp = model(A, B, op);
            tests++;
            if ({cout_c, ovf_c, sum_c} !== exp) begin
                fails++;
                $display("FAIL random_comb[%0d] A=%h B=%h op=%b: got %h, expected %h",
                         i, A, B, op, {cout_c, ovf_c, sum_c}, exp);
            end
            if (op) begin
                tests++;
                if ((sum_c[31] ^ ovf_c) !== ($signed(A) < $signed(B))) begin
                    fails++;
                    $display("FAIL random_slt[%0d] A=%h B=%h: got %b, expected %b",
                             i, A, B, sum_c[31] ^ ovf_c, $signed(A) < $signed(B));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [33:0] pending [$];
        logic [33:0] exp;
        @(posedge clk); #1;
        A = pick_operand(); B = pick_operand(); op = 1'($urandom_range(0, 1));
        pending.push_back(model(A, B, op));
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            exp = pending.pop_front();
            tests++;
            if ({cout_r, ovf_r, sum_r} !== exp) begin
                fails++;
                $display("FAIL back_to_back[%0d]: got %h, expected %h", i, {cout_r, ovf_r, sum_r}, exp);
            end
            A = pick_operand(); B = pick_operand(); op = 1'($urandom_range(0, 1));
            pending.push_back(model(A, B, op));
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        A = '0;
        B = '0;
        op = 1'b0;
        test_reset();
        test_directed();
        test_random_comb();
        test_back_to_back();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
